// File: rtl/mau_pkg.sv
// mau_pkg: state encoding, size codes and alignment helpers shared by mem_access_unit
package mau_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_DATA, S_WR} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lo[0] : |lo;
  endfunction
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_BYTE ? lo : size == SZ_HALF ? {lo[1], 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/mau_lane.sv
// mau_lane: little-endian lane extraction with sign/zero extension for loads and lane merge for stores
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] dm_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] merge_o
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  assign sh = {lane_i, 3'b000};
  assign b = 8'(dm_i >> sh);
  assign h = lane_i[1] ? dm_i[31:16] : dm_i[15:0];
  assign mask = (size_i == SZ_BYTE ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  // size 11 falls through to the whole-word paths
  always_comb begin
    ld_o = size_i == SZ_BYTE ? {{24{signed_i & b[7]}}, b} :
           size_i == SZ_HALF ? {{16{signed_i & h[15]}}, h} : dm_i;
    merge_o = size_i[1] ? wdata_i : (dm_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator with read-modify-write sub-word stores; MAU_ALIGN_CHECK_EN enables misalignment errors
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        Ready,
  output logic        Done,
  output logic        Err,
  output logic [31:0] RdData,
  output logic [29:0] Ad,
  output logic [31:0] WrData,
  output logic        MemWr,
  input  logic [31:0] DM
);
  state_t      state_q;
  logic        wr_q, sgn_q, done_q, err_q, mis;
  logic [1:0]  size_q;
  logic [31:0] addr_q, data_q, merge_q, rd_q, acc_addr, ld, mrg;
`ifdef MAU_ALIGN_CHECK_EN
  assign mis = misaligned(ReqSize, ReqAddr[1:0]);
  assign acc_addr = ReqAddr;
`else
  assign mis = 1'b0;
  assign acc_addr = {ReqAddr[31:2], force_align(ReqSize, ReqAddr[1:0])};
`endif
  mau_lane u_lane (
    .size_i  (size_q),
    .signed_i(sgn_q),
    .lane_i  (addr_q[1:0]),
    .dm_i    (DM),
    .wdata_i (data_q),
    .ld_o    (ld),
    .merge_o (mrg)
  );
  assign Ready = state_q == S_IDLE;
  assign Done = done_q;
  assign Err = err_q;
  assign RdData = rd_q;
  assign Ad = addr_q[31:2];
  assign WrData = size_q[1] ? data_q : merge_q;
  assign MemWr = state_q == S_WR && !Reset;
  // request FSM: latch on accept, read, merge or extract, write, then pulse Done
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= SZ_BYTE;
      addr_q <= '0;
      data_q <= '0;
      merge_q <= '0;
      rd_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (Req && mis) begin
            done_q <= 1'b1;
            err_q <= 1'b1;
          end else if (Req) begin
            wr_q <= ReqWr;
            sgn_q <= ReqSigned;
            size_q <= ReqSize;
            addr_q <= acc_addr;
            data_q <= ReqData;
            state_q <= ReqWr && ReqSize[1] ? S_WR : S_RD;
          end
        S_RD: state_q <= S_DATA;
        S_DATA:
          if (wr_q) begin
            merge_q <= mrg;
            state_q <= S_WR;
          end else begin
            rd_q <= ld;
            done_q <= 1'b1;
            state_q <= S_IDLE;
          end
        default: begin
          done_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, reset-in-write sequence and random ops against a byte-array reference model
module tb_mem_access_unit;
  logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0, ReqWr = 1'b0, ReqSigned = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic [31:0] ReqAddr = '0, ReqData = '0;
  logic        Ready, Done, Err, MemWr;
  logic [31:0] RdData, WrData, DM;
  logic [29:0] Ad;
  mem_access_unit dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWr(ReqWr), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqData(ReqData), .Ready(Ready),
    .Done(Done), .Err(Err), .RdData(RdData), .Ad(Ad), .WrData(WrData),
    .MemWr(MemWr), .DM(DM)
  );
  always #5 Clk = ~Clk;
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  int          wr_cnt = 0;
  logic [29:0] last_ad = '0;
  logic [31:0] last_wd = '0;
  // word memory with one-cycle registered read, plus a preload port
  always @(posedge Clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (MemWr) begin
      mem[Ad[5:0]] <= WrData;
      wr_cnt <= wr_cnt + 1;
      last_ad <= Ad;
      last_wd <= WrData;
    end
    DM <= mem[Ad[5:0]];
  end
  int tests = 0, fails = 0;
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rd = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e, output logic [31:0] r);
    int n, ea;
    logic [31:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    e = 1'b0;
    r = last_rd;
`ifdef MAU_ALIGN_CHECK_EN
    if (int'(a) % n != 0) begin
      lat = 1;
      e = 1'b1;
      return;
    end
`endif
    ea = int'(a[7:0]) - int'(a[7:0]) % n;
    if (wr) begin
      for (int i = 0; i < n; i++) ref_b[ea + i] = d[8*i +: 8];
      lat = n == 4 ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | ({24'b0, ref_b[ea + i]} << (8 * i));
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
      lat = 3;
      r = v;
      last_rd = v;
    end
  endtask
  task automatic op(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic [31:0] d, output int lat, output logic e, output logic [31:0] r);
    @(negedge Clk);
    Req = 1'b1; ReqWr = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqData = d;
    @(posedge Clk);
    #1 Req = 1'b0;
    lat = 0; e = 1'bx; r = 'x;
    for (int n = 1; n <= 8; n++) begin
      if (Done) begin
        lat = n; e = Err; r = RdData;
        break;
      end
      @(posedge Clk);
      #1;
    end
  endtask
  typedef struct {
    logic wr; logic [1:0] sz; logic sg; logic [31:0] a, d, rd;
    int lat; logic e; int nw; logic [29:0] ad; logic [31:0] wd;
  } vec_t;
  vec_t tbl [7];
  initial begin
    int lat, mlat, w0;
    logic e, me;
    logic [31:0] r, mr, w;
    tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 32'hFFFFFFAA, 3, 1'b0, 0, 30'h0, 32'h0};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 32'h00008899, 3, 1'b0, 0, 30'h0, 32'h0};
    tbl[2] = '{1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 32'hFFFF8899, 3, 1'b0, 0, 30'h0, 32'h0};
    tbl[3] = '{1'b1, 2'd0, 1'b0, 32'hB, 32'h5C, 32'hFFFF8899, 4, 1'b0, 1, 30'h2, 32'h5C99AABB};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h12345678, 32'hFFFF8899, 2, 1'b0, 1, 30'h1, 32'h12345678};
    tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h12345678, 3, 1'b0, 0, 30'h0, 32'h0};
`ifdef MAU_ALIGN_CHECK_EN
    tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 32'h12345678, 1, 1'b1, 0, 30'h0, 32'h0};
`else
    tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 32'h0000CAFE, 3, 1'b0, 0, 30'h0, 32'h0};
`endif
    for (int i = 0; i < 64; i++) begin
      w = i == 0 ? 32'hCAFE1234 : i == 2 ? 32'h8899AABB : i == 4 ? 32'h11223344 : $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
      @(negedge Clk);
      pre_en = 1'b1; pre_a = 6'(i); pre_d = w;
    end
    @(negedge Clk);
    pre_en = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_ready", {31'b0, Ready}, 32'd1);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    chk("rst_ad", {2'b0, Ad}, 32'd0);
    chk("rst_wrdata", WrData, 32'd0);
    chk("rst_memwr", {31'b0, MemWr}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      model(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d, mlat, me, mr);
      op(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d, lat, e, r);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].e});
      chk($sformatf("vec%0d_rd", i), r, tbl[i].rd);
      chk($sformatf("vec%0d_nwr", i), 32'(wr_cnt - w0), 32'(tbl[i].nw));
      if (tbl[i].nw == 1) begin
        chk($sformatf("vec%0d_ad", i), {2'b0, last_ad}, {2'b0, tbl[i].ad});
        chk($sformatf("vec%0d_wd", i), last_wd, tbl[i].wd);
      end
    end
    w0 = wr_cnt;
    @(negedge Clk);
    Req = 1'b1; ReqWr = 1'b1; ReqSize = 2'd0; ReqAddr = 32'h11; ReqData = 32'hEE;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("rstwr_memwr_before", {31'b0, MemWr}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rstwr_memwr_gated", {31'b0, MemWr}, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rstwr_done", {31'b0, Done}, 32'd0);
    chk("rstwr_ready", {31'b0, Ready}, 32'd1);
    chk("rstwr_nwr", 32'(wr_cnt - w0), 32'd0);
    chk("rstwr_mem", mem[4], 32'h11223344);
    chk("rstwr_rddata", RdData, 32'd0);
    last_rd = '0;
    for (int i = 0; i < 60; i++) begin
      logic rw, rs;
      logic [1:0] rz;
      logic [31:0] ra, rd_;
      rw = 1'($urandom); rs = 1'($urandom); rz = 2'($urandom);
      ra = $urandom_range(0, 255); rd_ = $urandom;
      model(rw, rz, rs, ra, rd_, mlat, me, mr);
      op(rw, rz, rs, ra, rd_, lat, e, r);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, me});
      chk($sformatf("rnd%0d_rd", i), r, mr);
      if (rw) chk($sformatf("rnd%0d_mem", i), mem[ra[7:2]], ref_word(int'(ra[7:2])));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU datapath and the word-organised data memory. Accepts one byte, halfword or word load/store per request, drives the memory's word address, write data and write enable, and returns extracted (sign- or zero-extended) load data with a one-cycle done pulse. Sub-word stores are performed as read-modify-write because the memory only writes whole words.

## Interface
Parameters:
- none; widths are fixed by the 32-bit datapath.

Ports:
- Clk  in  1  single clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  request strobe; sampled only while Ready=1.
- ReqWr  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- ReqAddr  in  32  byte address.
- ReqData  in  32  store data, right-aligned.
- Ready  out  1  high in IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  qualifies Done: misaligned request, no memory access made.
- RdData  out  32  load result, held until the next load completes.
- Ad  out  30  memory word address (byte address [31:2]).
- WrData  out  32  memory write data.
- MemWr  out  1  memory write enable.
- DM  in  32  memory read data, registered one cycle after Ad is presented with MemWr=0.

## Operation
- Little-endian byte lanes: lane = addr[1:0], lane 0 = bits 7:0; halfword lane = addr[1], lane 0 = bits 15:0.
- On accept (IDLE, Req=1), latch ReqWr/Size/Signed/Addr/Data. Memory outputs are driven from the latched values only.
- States:
  - IDLE: if misaligned (half with addr[0]=1, word with addr[1:0]≠0), set Done=1 and Err=1, and stay IDLE. Else a load or sub-word store goes to RD, and a word store goes to WR.
  - RD: Ad = addr[31:2], MemWr=0. The memory samples at this edge. Next state is DATA.
  - DATA: DM is valid. A load registers the extracted/extended value into RdData, pulses Done, and goes to IDLE. A store registers DM with the selected lane(s) replaced by ReqData's low bits into the merge register, then goes to WR.
  - WR: Ad = addr[31:2], WrData = merge register (word store: ReqData), MemWr=1 for exactly this cycle. At the edge, pulse Done and go to IDLE.
- MemWr = (state==WR) && !Reset. A write is never issued while Reset is high.
- Req while Ready=0 is ignored and not queued.
- Stores never change RdData. Err=1 never updates RdData.

## Timing
- Reset values: state IDLE, Ready 1, Done 0, Err 0, RdData 0, latched address/data 0, so Ad 0, WrData 0, MemWr 0.
- Done asserts N cycles after the accept edge and is high for 1 cycle:
  - Misaligned: N=1.
  - Word store: N=2.
  - Load: N=3.
  - Sub-word store: N=4.
- Ready returns high in the same cycle Done is high, so back-to-back requests are allowed. A Req in that cycle is accepted.
- Reset mid-operation (any state) goes to IDLE at that edge with no Done. Reset in the WR cycle suppresses MemWr combinationally.

## Configuration
- MAU_ALIGN_CHECK_EN defined: the misalignment check and Err behave as above.
- MAU_ALIGN_CHECK_EN undefined:
  - Err is tied 0.
  - Halfword addr[0] and word addr[1:0] are ignored, forcing alignment.
  - The access proceeds normally with the latencies above.

## Structure
- Package mau_pkg holds the state encoding (IDLE, RD, DATA, WR) and the size codes SZ_BYTE, SZ_HALF, SZ_WORD.
- One natural sub-module: mau_lane, combinational. It performs lane extraction with sign/zero extension for loads and lane merge for stores. The FSM and registers stay in mem_access_unit.

## Test plan
- Memory word 2 = 0x8899AABB. Signed byte load at 0x9 gives RdData=0xFFFFFFAA, with Done 3 cycles after accept and MemWr never high.
- Same word, unsigned half load at 0xA gives RdData=0x00008899. Signed half load gives 0xFFFF8899.
- Byte store 0x5C to 0xB: MemWr high 1 cycle with Ad=2 and WrData=0x5C99AABB. Done at cycle 4.
- Word store 0x12345678 to 0x4: no read cycle. MemWr high 1 cycle with Ad=1. Done at cycle 2. A back-to-back load from 0x4 in the Done cycle returns 0x12345678.
- Half load at 0x3 with MAU_ALIGN_CHECK_EN: Done=Err=1 one cycle later, RdData unchanged, MemWr/RD never entered. Without the macro, the access reads word 0 lane 1 (upper halfword).
- Sub-word store with Reset asserted in the WR cycle: MemWr stays 0, no Done, Ready=1 the next cycle, and the memory word is unchanged.
